// File: rtl/svx32_dmem_resp.sv
// Data-memory responder for the svx32 core: word RAM with byte-lane writes and WAIT_CYC wait states.
// Optional out-of-range address error reporting is enabled with `define SVX32_DMEM_ERR_EN.
module svx32_dmem_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_CYC   = 1
) (
    input  logic        pil_clk,
    input  logic        pil_rst_n,
    input  logic        pil_mem_req,
    input  logic        pil_mem_wen,
    input  logic [31:0] piv_mem_addr,
    input  logic [31:0] piv_mem_wdata,
    input  logic [3:0]  piv_mem_byte_sel,
    output logic        pol_mem_ack,
    output logic        pol_mem_valid,
    output logic [31:0] pov_mem_rdata,
    output logic        pol_mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RDATA} state_t;

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_wen;
    logic [31:0]           r_wdata;
    logic [3:0]            r_sel;
    logic                  r_oor;
    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_ram_q;

    logic w_cap;
    logic w_oor;
    logic w_we;
    logic w_ack;
    logic w_valid;
    logic w_unused_addr;

    assign w_cap = (r_state == S_IDLE) && pil_mem_req;

    // Only the word index feeds the RAM; the rest of the address wraps or flags an error.
    assign w_unused_addr = &{1'b0, piv_mem_addr[31:DEPTH_LOG2+2], piv_mem_addr[1:0]};

`ifdef SVX32_DMEM_ERR_EN
    assign w_oor       = |piv_mem_addr[31:DEPTH_LOG2+2];
    assign pol_mem_err = w_ack && r_oor;
`else
    assign w_oor       = 1'b0;
    assign pol_mem_err = 1'b0;
`endif

    always_ff @(posedge pil_clk or negedge pil_rst_n) begin
        if (!pil_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (pil_mem_req) w_next = (WAIT_CYC > 0) ? S_WAIT : S_ACK;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_ACK;
            S_ACK:   w_next = r_wen ? S_IDLE : S_RDATA;
            S_RDATA: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack   = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_ACK:   w_ack   = 1'b1;
            S_RDATA: w_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pil_clk or negedge pil_rst_n) begin
        if (!pil_rst_n) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wen   <= 1'b0;
            r_wdata <= 32'd0;
            r_sel   <= 4'd0;
            r_oor   <= 1'b0;
        end else if (w_cap) begin
            r_cnt   <= WAIT_LOAD;
            r_idx   <= piv_mem_addr[DEPTH_LOG2+1:2];
            r_wen   <= pil_mem_wen;
            r_wdata <= piv_mem_wdata;
            r_sel   <= piv_mem_byte_sel;
            r_oor   <= w_oor;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // RAM is never reset; the write commits only from ACK, so a reset earlier drops it.
    assign w_we = w_ack && r_wen && !r_oor;

    always_ff @(posedge pil_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && r_sel[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
        r_ram_q <= r_mem[r_idx];
    end

    assign pol_mem_ack   = w_ack;
    assign pol_mem_valid = w_valid;
    assign pov_mem_rdata = (w_valid && !r_oor) ? r_ram_q : 32'd0;

endmodule
